// File: rtl/sr_bank_ctrl.sv
// Round-robin sequencer for a bank of NOR SR latches: one set/clear pulse at a
// time, a readback check of the addressed latch, then an idle gap.
module sr_bank_ctrl #(
  parameter int N       = 8,
  parameter int PULSE_W = 2,
  parameter int GAP     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_vld,
  input  logic [1:0]             req_set,
  input  logic [2*$clog2(N)-1:0] req_idx,
  output logic [1:0]             req_rdy,
  output logic [N-1:0]           S,
  output logic [N-1:0]           R,
  input  logic [N-1:0]           Q,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  // state    | meaning
  // ST_IDLE  | arbitrate, accept one request
  // ST_PULSE | drive S or R of the captured latch for PULSE_W cycles
  // ST_CHECK | done pulse, compare Q of the captured latch with the op
  // ST_GAP   | GAP idle cycles before the next grant
  localparam int IDXW    = $clog2(N);
  localparam int CNT_MAX = (PULSE_W > GAP) ? PULSE_W : GAP;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_CHECK, ST_GAP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    cmd_oh;
  logic            cmd_set;
  logic            last_grant;

  logic            acc;
  logic            acc_sel;
  logic [IDXW-1:0] acc_idx;
  logic            acc_set;
  logic [N-1:0]    acc_oh;
  logic            acc_oor;
  logic            cmd_oor;
  logic            q_sel;

  always_comb begin
    req_rdy = 2'b00;
    if (state == ST_IDLE) begin
      if (req_vld == 2'b11) req_rdy = last_grant ? 2'b01 : 2'b10;
      else                  req_rdy = req_vld;
    end
  end

  assign acc     = |(req_vld & req_rdy);
  assign acc_sel = req_rdy[1];
  assign acc_idx = acc_sel ? req_idx[IDXW +: IDXW] : req_idx[0 +: IDXW];
  assign acc_set = req_set[acc_sel];

  // An index with no matching decode bit is out of range.
  always_comb begin
    acc_oh = '0;
    for (int i = 0; i < N; i++) acc_oh[i] = (acc_idx == IDXW'(i));
  end
  assign acc_oor = ~|acc_oh;

  assign cmd_oor = ~|cmd_oh;
  assign q_sel   = |(Q & cmd_oh);
  assign busy    = (state != ST_IDLE);
  assign err     = done & (cmd_oor | (q_sel != cmd_set));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      cmd_oh     <= '0;
      cmd_set    <= 1'b0;
      last_grant <= 1'b1;
      S          <= '0;
      R          <= '0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (acc) begin
            last_grant <= acc_sel;
            cmd_oh     <= acc_oh;
            cmd_set    <= acc_set;
            cnt        <= CW'(PULSE_W - 1);
            if (acc_oor) begin
              state <= ST_CHECK;
              done  <= 1'b1;
            end else begin
              state <= ST_PULSE;
              S     <= acc_set ? acc_oh : '0;
              R     <= acc_set ? '0 : acc_oh;
            end
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            S     <= '0;
            R     <= '0;
            done  <= 1'b1;
            state <= ST_CHECK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_CHECK: begin
          done <= 1'b0;
          if (GAP == 0) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_GAP;
            cnt   <= CW'(GAP - 1);
          end
        end
        ST_GAP: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// Bench for sr_bank_ctrl: directed vector table, corner-case sequences and
// random traffic checked every cycle against a timeline-based reference model.
module tb_sr_bank_ctrl;
  localparam int N  = 8;
  localparam int PW = 2;
  localparam int GP = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] vld, set, rdy;
  logic [5:0] idx;
  logic [7:0] s_o, r_o, q;
  logic       busy, done, err;
  logic [7:0] q_mem = '0;
  logic [7:0] stuck;

  logic [1:0] d6_vld, d6_set, d6_rdy;
  logic [5:0] d6_idx, d6_s, d6_r;
  logic [5:0] d6_q = '0;
  logic       d6_busy, d6_done, d6_err;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic chk_en = 1'b0;

  sr_bank_ctrl #(.N(N), .PULSE_W(PW), .GAP(GP)) dut (
    .clk(clk), .rst(rst), .req_vld(vld), .req_set(set), .req_idx(idx),
    .req_rdy(rdy), .S(s_o), .R(r_o), .Q(q), .busy(busy), .done(done), .err(err));

  sr_bank_ctrl #(.N(6), .PULSE_W(PW), .GAP(GP)) dut6 (
    .clk(clk), .rst(rst), .req_vld(d6_vld), .req_set(d6_set), .req_idx(d6_idx),
    .req_rdy(d6_rdy), .S(d6_s), .R(d6_r), .Q(d6_q), .busy(d6_busy), .done(d6_done),
    .err(d6_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Latch bank: S sets, R clears; stuck bits read back as 0.
  assign q = q_mem & ~stuck;
  always @(negedge clk)
    for (int i = 0; i < N; i++)
      if (s_o[i]) q_mem[i] <= 1'b1;
      else if (r_o[i]) q_mem[i] <= 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: remembers the last accepted command and its cycle number,
  // derives every output from the distance to that cycle.
  int   m_t = -1000, m_next = 0, m_idx = 0;
  logic m_valid = 1'b0, m_set = 1'b0, m_oor = 1'b0, m_last = 1'b1;

  always @(negedge clk) begin : model
    logic [1:0] e_rdy;
    logic [7:0] e_s, e_r;
    logic       e_busy, e_done, e_err, in_pulse;
    int         g;
    if (rst) begin
      m_valid = 1'b0;
      m_last  = 1'b1;
    end
    e_busy   = m_valid && cyc > m_t && cyc < m_next;
    e_rdy    = 2'b00;
    if (!e_busy) e_rdy = (vld == 2'b11) ? (m_last ? 2'b01 : 2'b10) : vld;
    in_pulse = m_valid && !m_oor && cyc > m_t && cyc <= m_t + PW;
    e_s      = (in_pulse && m_set)  ? (8'h01 << m_idx) : 8'h00;
    e_r      = (in_pulse && !m_set) ? (8'h01 << m_idx) : 8'h00;
    e_done   = m_valid && (cyc == m_t + (m_oor ? 1 : PW + 1));
    e_err    = e_done && (m_oor || (m_set && stuck[m_idx]));
    if (chk_en) begin
      chk("m_rdy", 32'(rdy), 32'(e_rdy));
      chk("m_S", 32'(s_o), 32'(e_s));
      chk("m_R", 32'(r_o), 32'(e_r));
      chk("m_busy", 32'(busy), 32'(e_busy));
      chk("m_done", 32'(done), 32'(e_done));
      chk("m_err", 32'(err), 32'(e_err));
      chk("inv_s_and_r", 32'(s_o & r_o), 32'd0);
      chk("inv_sr_onehot", 32'($countones(s_o | r_o) <= 1), 32'd1);
      chk("inv_rdy_onehot", 32'($countones(rdy) <= 1), 32'd1);
      chk("inv_rdy_busy", 32'(busy ? rdy : 2'b00), 32'd0);
    end
    if (!rst && (vld & e_rdy) != 2'b00) begin
      g       = int'(e_rdy[1]);
      m_t     = cyc;
      m_idx   = g ? int'(idx[5:3]) : int'(idx[2:0]);
      m_set   = set[g];
      m_oor   = (m_idx >= N);
      m_next  = cyc + (m_oor ? GP + 2 : PW + GP + 2);
      m_last  = e_rdy[1];
      m_valid = 1'b1;
    end
  end

  typedef struct packed {
    logic       pre_rst;
    logic [1:0] vld, set;
    logic [2:0] i0, i1;
    logic [1:0] rdy;
    logic [7:0] s, r;
    logic       busy, done, err;
  } vec_t;
  vec_t tv[17];

  task automatic do_reset();
    rst = 1'b1; vld = 2'b00; d6_vld = 2'b00;
    @(posedge clk); #1;
    chk("rst_S", 32'(s_o), 32'd0);
    chk("rst_R", 32'(r_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy6", 32'(d6_busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    for (c = 0; c < 30; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string nm, input logic exp_err);
    logic found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        chk({nm, "_err"}, 32'(err), 32'(exp_err));
      end
    end
    chk({nm, "_done_seen"}, 32'(found), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ng;
    logic exp_g;
    logic got;
    rst = 1'b1; vld = '0; set = '0; idx = '0; stuck = '0;
    d6_vld = '0; d6_set = '0; d6_idx = '0;

    //        pre   vld    set    i0    i1    rdy    S      R      busy  done  err
    tv[0]  = {1'b1, 2'b01, 2'b01, 3'd3, 3'd0, 2'b01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tv[1]  = {1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 2'b00, 8'h08, 8'h00, 1'b1, 1'b0, 1'b0};
    tv[2]  = {1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 2'b00, 8'h08, 8'h00, 1'b1, 1'b0, 1'b0};
    tv[3]  = {1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
    tv[4]  = {1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    tv[5]  = {1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tv[6]  = {1'b1, 2'b11, 2'b10, 3'd3, 3'd5, 2'b01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tv[7]  = {1'b0, 2'b11, 2'b10, 3'd3, 3'd5, 2'b00, 8'h00, 8'h08, 1'b1, 1'b0, 1'b0};
    tv[8]  = {1'b0, 2'b11, 2'b10, 3'd3, 3'd5, 2'b00, 8'h00, 8'h08, 1'b1, 1'b0, 1'b0};
    tv[9]  = {1'b0, 2'b11, 2'b10, 3'd3, 3'd5, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
    tv[10] = {1'b0, 2'b11, 2'b10, 3'd3, 3'd5, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    tv[11] = {1'b0, 2'b11, 2'b10, 3'd3, 3'd5, 2'b10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tv[12] = {1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 2'b00, 8'h20, 8'h00, 1'b1, 1'b0, 1'b0};
    tv[13] = {1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 2'b00, 8'h20, 8'h00, 1'b1, 1'b0, 1'b0};
    tv[14] = {1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
    tv[15] = {1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    tv[16] = {1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};

    do_reset();
    chk_en = 1'b1;

    // Single set, then both requesters contending from reset.
    for (int k = 0; k < 17; k++) begin
      if (tv[k].pre_rst) do_reset();
      vld = tv[k].vld; set = tv[k].set; idx = {tv[k].i1, tv[k].i0};
      @(negedge clk);
      chk($sformatf("row%0d_rdy", k), 32'(rdy), 32'(tv[k].rdy));
      chk($sformatf("row%0d_S", k), 32'(s_o), 32'(tv[k].s));
      chk($sformatf("row%0d_R", k), 32'(r_o), 32'(tv[k].r));
      chk($sformatf("row%0d_busy", k), 32'(busy), 32'(tv[k].busy));
      chk($sformatf("row%0d_done", k), 32'(done), 32'(tv[k].done));
      chk($sformatf("row%0d_err", k), 32'(err), 32'(tv[k].err));
      @(posedge clk); #1;
    end

    // Back-to-back contention: grants must alternate starting with requester 0.
    vld = 2'b11; set = 2'($urandom); idx = 6'($urandom);
    ng = 0; exp_g = 1'b0;
    for (int c = 0; c < 200 && ng < 6; c++) begin
      @(negedge clk);
      got = ((vld & rdy) != 2'b00);
      if (got) begin
        chk($sformatf("rr_grant%0d", ng), 32'(rdy), exp_g ? 32'd2 : 32'd1);
        exp_g = ~exp_g;
        ng++;
      end
      @(posedge clk); #1;
      if (got) begin set = 2'($urandom); idx = 6'($urandom); end
    end
    chk("rr_count", 32'(ng), 32'd6);
    vld = 2'b00;
    wait_idle();

    // Q[2] stuck low: a set must flag err together with done.
    stuck = 8'h04; vld = 2'b01; set = 2'b01; idx = 6'd2;
    @(negedge clk);
    chk("stuck_acc", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    vld = 2'b00;
    wait_done("stuck", 1'b1);
    wait_idle();
    stuck = 8'h00;

    // Reset in the second pulse cycle of a set.
    vld = 2'b01; set = 2'b01; idx = 6'd6;
    @(negedge clk);
    chk("rstmid_acc", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    vld = 2'b00;
    @(posedge clk); #1;
    chk("rstmid_pulse2", 32'(s_o), 32'h40);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_S", 32'(s_o), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rstmid_no_done", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    vld = 2'b10; set = 2'b00; idx = {3'd6, 3'd0};
    @(negedge clk);
    chk("rstmid_next_acc", 32'(rdy), 32'd2);
    @(posedge clk); #1;
    vld = 2'b00;
    wait_done("rstmid_next", 1'b0);
    wait_idle();

    // N=6 instance, index 7 is out of range.
    d6_vld = 2'b01; d6_set = 2'b01; d6_idx = {3'd0, 3'd7};
    @(negedge clk);
    chk("oor_rdy", 32'(d6_rdy), 32'd1);
    chk("oor_busy0", 32'(d6_busy), 32'd0);
    @(posedge clk); #1;
    d6_vld = 2'b00;
    @(negedge clk);
    chk("oor_done", 32'(d6_done), 32'd1);
    chk("oor_err", 32'(d6_err), 32'd1);
    chk("oor_busy1", 32'(d6_busy), 32'd1);
    chk("oor_sr", 32'({d6_s, d6_r}), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("oor_gap_busy", 32'(d6_busy), 32'd1);
    chk("oor_gap_done", 32'(d6_done), 32'd0);
    chk("oor_gap_sr", 32'({d6_s, d6_r}), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("oor_idle", 32'(d6_busy), 32'd0);
    @(posedge clk); #1;

    // Random traffic with occasional stuck-low latches.
    for (int c = 0; c < 400; c++) begin
      vld = 2'($urandom_range(0, 3));
      set = 2'($urandom);
      idx = 6'($urandom);
      if (c % 50 == 0) stuck = 8'($urandom) & 8'($urandom) & 8'($urandom);
      @(posedge clk); #1;
    end
    vld = 2'b00;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
